// File: rtl/snitch_icache_miss_arbiter.sv
// rtl/snitch_icache_miss_arbiter.sv - round-robin arbiter merging L0 refill misses onto one L1 lookup port
//
// Collects line-miss requests from NR_FETCH_PORTS L0 caches, grants one per
// cycle in round-robin order into a single register slice toward the L1
// lookup, and routes the L1 responses back to the issuing port by ID.
// Each port may have only one miss outstanding; a busy bit tracks it.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   in_addr_i / in_valid_i        per-port miss line address and valid
//   in_ready_o                    per-port grant (at most one bit high)
//   in_rsp_data_o / _error_o      refill line and error, broadcast
//   in_rsp_valid_o / _ready_i     per-port response handshake
//   out_addr_o / out_id_o         registered request toward L1
//   out_valid_o / out_ready_i     L1 request handshake
//   out_rsp_*                     L1 response (data, error, id, handshake)
module snitch_icache_miss_arbiter #(
    parameter int unsigned NR_FETCH_PORTS = 4,
    parameter int unsigned FETCH_AW       = 32,
    parameter int unsigned LINE_WIDTH     = 128,
    parameter int unsigned ID_WIDTH       = (NR_FETCH_PORTS > 1) ? $clog2(NR_FETCH_PORTS) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,

    input  logic [NR_FETCH_PORTS*FETCH_AW-1:0] in_addr_i,
    input  logic [NR_FETCH_PORTS-1:0]          in_valid_i,
    output logic [NR_FETCH_PORTS-1:0]          in_ready_o,

    output logic [LINE_WIDTH-1:0]              in_rsp_data_o,
    output logic                               in_rsp_error_o,
    output logic [NR_FETCH_PORTS-1:0]          in_rsp_valid_o,
    input  logic [NR_FETCH_PORTS-1:0]          in_rsp_ready_i,

    output logic [FETCH_AW-1:0]                out_addr_o,
    output logic [ID_WIDTH-1:0]                out_id_o,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,

    input  logic [LINE_WIDTH-1:0]              out_rsp_data_i,
    input  logic                               out_rsp_error_i,
    input  logic [ID_WIDTH-1:0]                out_rsp_id_i,
    input  logic                               out_rsp_valid_i,
    output logic                               out_rsp_ready_o
);

    // One extra bit so that rr + offset can exceed NR_FETCH_PORTS-1 before wrapping.
    localparam int unsigned CW = ID_WIDTH + 1;

    logic [NR_FETCH_PORTS-1:0] busy_q, busy_d;
    logic [ID_WIDTH-1:0]       rr_q, rr_d;
    logic                      out_valid_q;
    logic [FETCH_AW-1:0]       out_addr_q;
    logic [ID_WIDTH-1:0]       out_id_q;

    logic [NR_FETCH_PORTS-1:0] eligible;
    logic                      stage_free;
    logic                      grant_valid;
    logic [ID_WIDTH-1:0]       grant_idx;
    logic [NR_FETCH_PORTS-1:0] grant_oh;
    logic                      take;
    logic [FETCH_AW-1:0]       grant_addr;

    logic [NR_FETCH_PORTS-1:0] rsp_oh;
    logic                      rsp_hit;
    logic [NR_FETCH_PORTS-1:0] rsp_clear;

    // Busy is the registered value: a port whose response completes this
    // cycle is still ineligible until the next one.
    assign eligible   = in_valid_i & ~busy_q;
    assign stage_free = !out_valid_q || out_ready_i;

    // Round-robin search: first eligible port at or after rr, wrapping.
    always_comb begin : p_arbitrate
        logic [CW-1:0]             cand;
        logic [NR_FETCH_PORTS-1:0] rot;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        rot         = '0;
        for (int i = 0; i < int'(NR_FETCH_PORTS); i++) begin
            cand = {1'b0, rr_q} + CW'(i);
            if (cand >= CW'(NR_FETCH_PORTS)) begin
                cand = cand - CW'(NR_FETCH_PORTS);
            end
            rot = eligible >> cand;
            if (!grant_valid && rot[0]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[ID_WIDTH-1:0];
            end
        end
    end

    assign grant_oh   = (grant_valid && stage_free && rst_ni)
                      ? (NR_FETCH_PORTS'(1) << grant_idx) : '0;
    assign take       = |grant_oh;
    assign in_ready_o = grant_oh;

    always_comb begin : p_addr_mux
        grant_addr = '0;
        for (int p = 0; p < int'(NR_FETCH_PORTS); p++) begin
            if (grant_idx == ID_WIDTH'(p)) begin
                grant_addr = in_addr_i[p*FETCH_AW +: FETCH_AW];
            end
        end
    end

    always_comb begin : p_rr_next
        logic [CW-1:0] nxt;
        nxt = {1'b0, grant_idx} + CW'(1);
        if (nxt >= CW'(NR_FETCH_PORTS)) begin
            nxt = '0;
        end
        rr_d = take ? nxt[ID_WIDTH-1:0] : rr_q;
    end

    // An out-of-range ID shifts the one-hot to zero, so it can never hit a
    // busy port; such responses and those for idle ports are absorbed.
    assign rsp_oh          = NR_FETCH_PORTS'(1) << out_rsp_id_i;
    assign rsp_hit         = |(busy_q & rsp_oh);
    assign in_rsp_valid_o  = out_rsp_valid_i ? (busy_q & rsp_oh) : '0;
    assign out_rsp_ready_o = rsp_hit ? |(in_rsp_ready_i & rsp_oh) : 1'b1;
    assign in_rsp_data_o   = out_rsp_data_i;
    assign in_rsp_error_o  = out_rsp_error_i;

    assign rsp_clear = in_rsp_valid_o & in_rsp_ready_i;
    // Grant and clear never target the same port: grant needs busy=0, clear busy=1.
    assign busy_d    = (busy_q | grant_oh) & ~rsp_clear;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q      <= '0;
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_id_q    <= '0;
        end else begin
            busy_q <= busy_d;
            rr_q   <= rr_d;
            if (take) begin
                out_valid_q <= 1'b1;
                out_addr_q  <= grant_addr;
                out_id_q    <= grant_idx;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_addr_o  = out_addr_q;
    assign out_id_o    = out_id_q;

    stray_rsp_dropped : assert property (
        @(posedge clk_i) disable iff (!rst_ni) out_rsp_valid_i |-> rsp_hit
    ) else $warning("refill response with id %0d dropped: port not waiting", out_rsp_id_i);

endmodule

// File: tb/tb_snitch_icache_miss_arbiter.sv
// tb/tb_snitch_icache_miss_arbiter.sv - directed self-checking bench for snitch_icache_miss_arbiter
module tb_snitch_icache_miss_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 128;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*AW-1:0] in_addr = '0;
    logic [N-1:0]    in_valid = '0;
    logic [N-1:0]    in_ready;
    logic [LW-1:0]   in_rsp_data;
    logic            in_rsp_error;
    logic [N-1:0]    in_rsp_valid;
    logic [N-1:0]    in_rsp_ready = '1;
    logic [AW-1:0]   out_addr;
    logic [IW-1:0]   out_id;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [LW-1:0]   out_rsp_data = '0;
    logic            out_rsp_error = 1'b0;
    logic [IW-1:0]   out_rsp_id = '0;
    logic            out_rsp_valid = 1'b0;
    logic            out_rsp_ready;

    int errors = 0;
    int checks = 0;

    snitch_icache_miss_arbiter #(
        .NR_FETCH_PORTS(N), .FETCH_AW(AW), .LINE_WIDTH(LW), .ID_WIDTH(IW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_addr_i(in_addr), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_rsp_data_o(in_rsp_data), .in_rsp_error_o(in_rsp_error),
        .in_rsp_valid_o(in_rsp_valid), .in_rsp_ready_i(in_rsp_ready),
        .out_addr_o(out_addr), .out_id_o(out_id), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_rsp_data_i(out_rsp_data), .out_rsp_error_i(out_rsp_error), .out_rsp_id_i(out_rsp_id),
        .out_rsp_valid_i(out_rsp_valid), .out_rsp_ready_o(out_rsp_ready)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = '0; out_ready = 1'b0; out_rsp_valid = 1'b0; in_rsp_ready = '1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        in_valid = 4'b1111; out_ready = 1'b1;
        in_addr[0*AW +: AW] = 32'h0000_0040;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL reset_out_addr: got %h expected 0", out_addr); end
        checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL reset_out_id: got %0d expected 0", out_id); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
        @(negedge clk);
        rst_n = 1'b1; in_valid = '0;
    endtask

    task automatic test_single();
        @(negedge clk);
        in_addr[2*AW +: AW] = 32'h0000_1000; in_valid = 4'b0100; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected 0100", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_id !== 2'd2 || out_addr !== 32'h0000_1000) begin
            errors++; $display("FAIL single_out: got v=%b id=%0d addr=%h expected v=1 id=2 addr=00001000", out_valid, out_id, out_addr);
        end
        @(negedge clk);
        in_valid = '0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b expected 0", out_valid); end
        @(negedge clk);
        out_rsp_valid = 1'b1; out_rsp_id = 2'd2; in_rsp_ready = 4'b1111;
        out_rsp_data = {4{32'hCAFE_F00D}}; out_rsp_error = 1'b1;
        #1;
        checks++; if (in_rsp_valid !== 4'b0100 || out_rsp_ready !== 1'b1) begin
            errors++; $display("FAIL single_rsp_route: got valid=%b ready=%b expected valid=0100 ready=1", in_rsp_valid, out_rsp_ready);
        end
        checks++; if (in_rsp_data !== {4{32'hCAFE_F00D}} || in_rsp_error !== 1'b1) begin
            errors++; $display("FAIL single_rsp_data: got data=%h err=%b expected cafef00d x4 err=1", in_rsp_data, in_rsp_error);
        end
        @(negedge clk);
        out_rsp_valid = 1'b0; out_rsp_error = 1'b0;
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_rdy;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_valid = 4'b1111; out_ready = 1'b1; in_rsp_ready = 4'b1111;
            out_rsp_valid = out_valid; out_rsp_id = out_id;
            exp_rdy = 4'b0001 << (k % 4);
            #1;
            checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL fair_grant_%0d: got %b expected %b", k, in_ready, exp_rdy); end
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || out_id !== IW'(k % 4)) begin
                errors++; $display("FAIL fair_out_%0d: got v=%b id=%0d expected v=1 id=%0d", k, out_valid, out_id, k % 4);
            end
        end
        @(negedge clk);
        in_valid = '0; out_rsp_valid = out_valid; out_rsp_id = out_id;
        @(negedge clk);
        out_rsp_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        in_addr[1*AW +: AW] = 32'h0000_AAA0; in_addr[2*AW +: AW] = 32'h0000_BBB0;
        in_valid = 4'b0110; out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL bp_first_grant: got %b expected 0010", in_ready); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_in_ready_%0d: got %b expected 0000", c, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_id !== 2'd1 || out_addr !== 32'h0000_AAA0) begin
                errors++; $display("FAIL bp_hold_%0d: got v=%b id=%0d addr=%h expected v=1 id=1 addr=0000aaa0", c, out_valid, out_id, out_addr);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_grant: got %b expected 0100", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_id !== 2'd2 || out_addr !== 32'h0000_BBB0) begin
            errors++; $display("FAIL bp_next_out: got id=%0d addr=%h expected id=2 addr=0000bbb0", out_id, out_addr);
        end
        @(negedge clk);
        in_valid = '0; out_rsp_valid = 1'b1; out_rsp_id = 2'd1;
        @(negedge clk);
        out_rsp_id = 2'd2;
        @(negedge clk);
        out_rsp_valid = 1'b0;
    endtask

    task automatic test_busy_block();
        @(negedge clk);
        in_addr[1*AW +: AW] = 32'h0000_2000; in_valid = 4'b0010; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL busy_first_grant: got %b expected 0010", in_ready); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL busy_blocked_%0d: got %b expected 0000", c, in_ready); end
        end
        @(negedge clk);
        out_rsp_valid = 1'b1; out_rsp_id = 2'd1;
        #1;
        checks++; if (in_ready !== 4'b0000 || in_rsp_valid !== 4'b0010) begin
            errors++; $display("FAIL busy_same_cycle: got ready=%b rsp_valid=%b expected ready=0000 rsp_valid=0010", in_ready, in_rsp_valid);
        end
        @(negedge clk);
        out_rsp_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL busy_regrant: got %b expected 0010", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_id !== 2'd1) begin
            errors++; $display("FAIL busy_regrant_out: got v=%b id=%0d expected v=1 id=1", out_valid, out_id);
        end
        @(negedge clk);
        in_valid = '0; out_rsp_valid = 1'b1; out_rsp_id = 2'd1;
        @(negedge clk);
        out_rsp_valid = 1'b0;
    endtask

    task automatic test_out_of_order();
        @(negedge clk);
        in_valid = 4'b1001; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL ooo_grant_3: got %b expected 1000", in_ready); end
        @(negedge clk); #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL ooo_grant_0: got %b expected 0001", in_ready); end
        @(negedge clk);
        in_valid = '0; out_rsp_valid = 1'b1; out_rsp_id = 2'd3; in_rsp_ready = 4'b1111;
        #1;
        checks++; if (in_rsp_valid !== 4'b1000 || out_rsp_ready !== 1'b1) begin
            errors++; $display("FAIL ooo_rsp3: got valid=%b ready=%b expected valid=1000 ready=1", in_rsp_valid, out_rsp_ready);
        end
        @(negedge clk);
        out_rsp_id = 2'd0; in_rsp_ready = 4'b0000;
        #1;
        checks++; if (in_rsp_valid !== 4'b0001 || out_rsp_ready !== 1'b0) begin
            errors++; $display("FAIL ooo_rsp0_stall: got valid=%b ready=%b expected valid=0001 ready=0", in_rsp_valid, out_rsp_ready);
        end
        @(negedge clk);
        out_rsp_id = 2'd3;
        #1;
        checks++; if (in_rsp_valid !== 4'b0000 || out_rsp_ready !== 1'b1) begin
            errors++; $display("FAIL ooo_rsp3_again: got valid=%b ready=%b expected valid=0000 ready=1", in_rsp_valid, out_rsp_ready);
        end
        @(negedge clk);
        out_rsp_id = 2'd1;
        #1;
        checks++; if (in_rsp_valid !== 4'b0000 || out_rsp_ready !== 1'b1) begin
            errors++; $display("FAIL ooo_stray1: got valid=%b ready=%b expected valid=0000 ready=1", in_rsp_valid, out_rsp_ready);
        end
        @(negedge clk);
        out_rsp_id = 2'd0; in_rsp_ready = 4'b0001;
        #1;
        checks++; if (in_rsp_valid !== 4'b0001 || out_rsp_ready !== 1'b1) begin
            errors++; $display("FAIL ooo_rsp0: got valid=%b ready=%b expected valid=0001 ready=1", in_rsp_valid, out_rsp_ready);
        end
        @(negedge clk); #1;
        checks++; if (in_rsp_valid !== 4'b0000 || out_rsp_ready !== 1'b1) begin
            errors++; $display("FAIL ooo_rsp0_again: got valid=%b ready=%b expected valid=0000 ready=1", in_rsp_valid, out_rsp_ready);
        end
        @(negedge clk);
        out_rsp_valid = 1'b0; in_rsp_ready = 4'b1111;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_addr[1*AW +: AW] = 32'h0000_3000; in_addr[2*AW +: AW] = 32'h0000_4000;
        in_valid = 4'b0110; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL rmid_grant_1: got %b expected 0010", in_ready); end
        @(negedge clk); #1;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL rmid_grant_2: got %b expected 0100", in_ready); end
        @(negedge clk);
        in_valid = '0; out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_id !== 2'd2) begin
            errors++; $display("FAIL rmid_pre: got v=%b id=%0d expected v=1 id=2", out_valid, out_id);
        end
        rst_n = 1'b0; in_valid = 4'b1111;
        #1;
        checks++; if (out_valid !== 1'b0 || out_addr !== 32'h0 || out_id !== 2'd0 || in_ready !== 4'b0000) begin
            errors++; $display("FAIL rmid_async: got v=%b addr=%h id=%0d rdy=%b expected all zero", out_valid, out_addr, out_id, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL rmid_after_0: got %b expected 0001", in_ready); end
        @(negedge clk); #1;
        checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL rmid_after_1: got %b expected 0010", in_ready); end
        @(negedge clk);
        in_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_busy_block();
        test_out_of_order();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
